// File: rtl/ram_arbiter.sv
// ram_arbiter: clocked arbiter sharing one single-port synchronous RAM between
// the stage12 fetch reader, the stage3 operand reader and the stage5 saver.
// Priority is stage3 > stage5 > stage12, except that a stage12 request that
// has waited STARVE_LIMIT cycles is promoted above both.
//
// Handshake (all three ports, four-phase): a requester raises its level
// request with address/data stable and keeps it high until it sees its
// one-cycle ready pulse. It must then drop the request for at least one
// sampled edge before it can be served again. A request still high after
// ready is ignored, and a request dropped before its grant is discarded.
module ram_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              ram_clk,
    input  logic              rst,

    input  logic              stage12_read,
    input  logic [ADDR_W-1:0] stage12_read_address,
    output logic              stage12_read_ready,
    output logic [DATA_W-1:0] stage12_read_data_out,

    input  logic              stage3_read,
    input  logic [ADDR_W-1:0] stage3_read_address,
    output logic              stage3_read_ready,
    output logic [DATA_W-1:0] stage3_read_data_out,

    input  logic              stage5_save,
    input  logic [ADDR_W-1:0] stage5_save_address,
    input  logic [DATA_W-1:0] stage5_save_data_in,
    output logic              stage5_save_ready,

    output logic              ram_write_enable,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out,

    output logic              busy,
    output logic [1:0]        grant,

    output logic [1:0]        state_dbg,
    output logic [7:0]        starve_cnt_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_CAP  = 2'd2,
        WR      = 2'd3
    } state_t;

    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_S12  = 2'd1;
    localparam logic [1:0] G_S3   = 2'd2;
    localparam logic [1:0] G_S5   = 2'd3;
    localparam logic [7:0] LIMIT  = 8'(STARVE_LIMIT);

    state_t     state;
    state_t     next_state;
    logic [1:0] win;
    logic       promote;
    logic       armed12;
    logic       armed3;
    logic       armed5;
    logic [7:0] starve_cnt;

    assign busy           = (state != IDLE);
    assign state_dbg      = state;
    assign starve_cnt_dbg = starve_cnt;

    // State register.
    always_ff @(posedge ram_clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // Arbitration in IDLE and the fixed read/write sequencing elsewhere.
    always_comb begin
        next_state = state;
        win        = G_NONE;
        promote    = stage12_read && armed12 && (starve_cnt == LIMIT);
        case (state)
            IDLE: begin
                if (promote)                     win = G_S12;
                else if (stage3_read && armed3)  win = G_S3;
                else if (stage5_save && armed5)  win = G_S5;
                else if (stage12_read && armed12) win = G_S12;
                if (win == G_S5)          next_state = WR;
                else if (win != G_NONE)   next_state = RD_WAIT;
            end
            RD_WAIT: next_state = RD_CAP;
            RD_CAP:  next_state = IDLE;
            WR:      next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // RAM drive, grant ownership, read-data capture and ready pulses.
    always_ff @(posedge ram_clk or negedge rst) begin
        if (!rst) begin
            grant                 <= G_NONE;
            ram_write_enable      <= 1'b0;
            ram_address           <= '0;
            ram_data_in           <= '0;
            stage12_read_ready    <= 1'b0;
            stage3_read_ready     <= 1'b0;
            stage5_save_ready     <= 1'b0;
            stage12_read_data_out <= '0;
            stage3_read_data_out  <= '0;
        end else begin
            stage12_read_ready <= 1'b0;
            stage3_read_ready  <= 1'b0;
            stage5_save_ready  <= 1'b0;
            case (state)
                IDLE: begin
                    grant <= win;
                    case (win)
                        G_S12: begin
                            ram_address      <= stage12_read_address;
                            ram_write_enable <= 1'b0;
                        end
                        G_S3: begin
                            ram_address      <= stage3_read_address;
                            ram_write_enable <= 1'b0;
                        end
                        G_S5: begin
                            ram_address      <= stage5_save_address;
                            ram_data_in      <= stage5_save_data_in;
                            ram_write_enable <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                RD_CAP: begin
                    // ram_data_out was registered by the RAM on the RD_WAIT edge.
                    case (grant)
                        G_S12: begin
                            stage12_read_data_out <= ram_data_out;
                            stage12_read_ready    <= 1'b1;
                        end
                        G_S3: begin
                            stage3_read_data_out <= ram_data_out;
                            stage3_read_ready    <= 1'b1;
                        end
                        default: ;
                    endcase
                    grant <= G_NONE;
                end
                WR: begin
                    ram_write_enable  <= 1'b0;
                    stage5_save_ready <= 1'b1;
                    grant             <= G_NONE;
                end
                default: ;
            endcase
        end
    end

    // Per-port arming: cleared at completion, restored once the request is seen low.
    always_ff @(posedge ram_clk or negedge rst) begin
        if (!rst) begin
            armed12 <= 1'b1;
            armed3  <= 1'b1;
            armed5  <= 1'b1;
        end else begin
            if (state == RD_CAP && grant == G_S12) armed12 <= 1'b0;
            else if (!stage12_read)                armed12 <= 1'b1;

            if (state == RD_CAP && grant == G_S3)  armed3 <= 1'b0;
            else if (!stage3_read)                 armed3 <= 1'b1;

            if (state == WR)                       armed5 <= 1'b0;
            else if (!stage5_save)                 armed5 <= 1'b1;
        end
    end

    // Fetch starvation counter: counts waiting cycles of an armed, pending stage12.
    always_ff @(posedge ram_clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= 8'd0;
        end else if (!stage12_read || win == G_S12 || grant == G_S12) begin
            starve_cnt <= 8'd0;
        end else if (armed12 && starve_cnt < LIMIT) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench for ram_arbiter with a behavioural
// single-port synchronous RAM attached to the arbiter's RAM port.
module tb_ram_arbiter;

    localparam int ADDR_W       = 16;
    localparam int DATA_W       = 8;
    localparam int STARVE_LIMIT = 8;

    logic              ram_clk;
    logic              rst;
    logic              stage12_read;
    logic [ADDR_W-1:0] stage12_read_address;
    logic              stage12_read_ready;
    logic [DATA_W-1:0] stage12_read_data_out;
    logic              stage3_read;
    logic [ADDR_W-1:0] stage3_read_address;
    logic              stage3_read_ready;
    logic [DATA_W-1:0] stage3_read_data_out;
    logic              stage5_save;
    logic [ADDR_W-1:0] stage5_save_address;
    logic [DATA_W-1:0] stage5_save_data_in;
    logic              stage5_save_ready;
    logic              ram_write_enable;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data_in;
    logic [DATA_W-1:0] ram_data_out;
    logic              busy;
    logic [1:0]        grant;
    logic [1:0]        state_dbg;
    logic [7:0]        starve_cnt_dbg;

    logic [DATA_W-1:0] mem [0:65535];
    logic [1:0]        exp_q[$];
    int                tests;
    int                fails;

    ram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .ram_clk(ram_clk), .rst(rst),
        .stage12_read(stage12_read), .stage12_read_address(stage12_read_address),
        .stage12_read_ready(stage12_read_ready), .stage12_read_data_out(stage12_read_data_out),
        .stage3_read(stage3_read), .stage3_read_address(stage3_read_address),
        .stage3_read_ready(stage3_read_ready), .stage3_read_data_out(stage3_read_data_out),
        .stage5_save(stage5_save), .stage5_save_address(stage5_save_address),
        .stage5_save_data_in(stage5_save_data_in), .stage5_save_ready(stage5_save_ready),
        .ram_write_enable(ram_write_enable), .ram_address(ram_address),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
        .busy(busy), .grant(grant),
        .state_dbg(state_dbg), .starve_cnt_dbg(starve_cnt_dbg)
    );

    // Clock.
    initial begin
        ram_clk = 1'b0;
        forever #5 ram_clk = ~ram_clk;
    end

    // Single-port synchronous RAM: write and registered read on the rising edge.
    always @(posedge ram_clk) begin
        if (ram_write_enable) mem[ram_address] <= ram_data_in;
        ram_data_out <= mem[ram_address];
    end

    task automatic tick();
        @(negedge ram_clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic ready_of(input int port);
        case (port)
            1:       return stage12_read_ready;
            2:       return stage3_read_ready;
            default: return stage5_save_ready;
        endcase
    endfunction

    // Number of negedges until the port's ready is seen, or -1 on timeout.
    task automatic wait_ready(input int port, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (ready_of(port)) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int nrdy;
        int port;
        int pulses;
        int gcycles;
        bit seen;

        tests = 0;
        fails = 0;
        mem[16'h0004] <= 8'h11;
        mem[16'h0030] <= 8'h77;
        rst = 1'b0;
        stage12_read = 1'b0; stage12_read_address = '0;
        stage3_read  = 1'b0; stage3_read_address  = '0;
        stage5_save  = 1'b0; stage5_save_address  = '0; stage5_save_data_in = '0;

        // Reset values.
        tick(); tick();
        check("rst_rdy12", 32'(stage12_read_ready), 32'd0);
        check("rst_rdy3", 32'(stage3_read_ready), 32'd0);
        check("rst_rdy5", 32'(stage5_save_ready), 32'd0);
        check("rst_dout12", 32'(stage12_read_data_out), 32'd0);
        check("rst_dout3", 32'(stage3_read_data_out), 32'd0);
        check("rst_we", 32'(ram_write_enable), 32'd0);
        check("rst_addr", 32'(ram_address), 32'd0);
        check("rst_din", 32'(ram_data_in), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_cnt", 32'(starve_cnt_dbg), 32'd0);
        rst = 1'b1;
        tick();

        // Fetch read of 0x0004: ready 3 edges after the request is sampled.
        stage12_read = 1'b1; stage12_read_address = 16'h0004;
        tick();
        check("rd12_grant_e0", 32'(grant), 32'd1);
        check("rd12_busy_e0", 32'(busy), 32'd1);
        check("rd12_addr", 32'(ram_address), 32'h0004);
        check("rd12_rdy_e0", 32'(stage12_read_ready), 32'd0);
        tick();
        check("rd12_grant_e1", 32'(grant), 32'd1);
        check("rd12_rdy_e1", 32'(stage12_read_ready), 32'd0);
        tick();
        check("rd12_rdy_e2", 32'(stage12_read_ready), 32'd1);
        check("rd12_data", 32'(stage12_read_data_out), 32'h11);
        check("rd12_grant_done", 32'(grant), 32'd0);
        stage12_read = 1'b0;
        tick();
        check("rd12_rdy_pulse", 32'(stage12_read_ready), 32'd0);
        check("rd12_data_hold", 32'(stage12_read_data_out), 32'h11);

        // Save 0x0010 <- 0xA5, then read it back through stage3.
        stage5_save = 1'b1; stage5_save_address = 16'h0010; stage5_save_data_in = 8'hA5;
        tick();
        check("wr_we_e0", 32'(ram_write_enable), 32'd1);
        check("wr_grant", 32'(grant), 32'd3);
        check("wr_rdy_e0", 32'(stage5_save_ready), 32'd0);
        tick();
        check("wr_rdy_e1", 32'(stage5_save_ready), 32'd1);
        check("wr_we_e1", 32'(ram_write_enable), 32'd0);
        check("wr_mem", 32'(mem[16'h0010]), 32'hA5);
        stage5_save = 1'b0;
        stage3_read = 1'b1; stage3_read_address = 16'h0010;
        wait_ready(2, 10, n);
        check("rd3_latency", 32'(n), 32'd3);
        check("rd3_data", 32'(stage3_read_data_out), 32'hA5);
        stage3_read = 1'b0;
        tick();

        // All three request together: served stage3, stage5, stage12.
        exp_q = {2'd2, 2'd3, 2'd1};
        stage12_read = 1'b1; stage12_read_address = 16'h0004;
        stage3_read  = 1'b1; stage3_read_address  = 16'h0010;
        stage5_save  = 1'b1; stage5_save_address  = 16'h0020; stage5_save_data_in = 8'h5A;
        for (int i = 0; i < 30 && exp_q.size() > 0; i++) begin
            tick();
            nrdy = int'(stage12_read_ready) + int'(stage3_read_ready) + int'(stage5_save_ready);
            if (nrdy > 0) begin
                check("ready_overlap", 32'(nrdy), 32'd1);
                port = stage3_read_ready ? 2 : (stage5_save_ready ? 3 : 1);
                check("order", 32'(port), 32'(exp_q.pop_front()));
                if (port == 1) stage12_read = 1'b0;
                if (port == 2) stage3_read  = 1'b0;
                if (port == 3) stage5_save  = 1'b0;
            end
        end
        check("order_done", 32'(exp_q.size()), 32'd0);
        check("all_dout12", 32'(stage12_read_data_out), 32'h11);
        check("all_dout3", 32'(stage3_read_data_out), 32'hA5);
        check("all_mem20", 32'(mem[16'h0020]), 32'h5A);
        stage12_read = 1'b0; stage3_read = 1'b0; stage5_save = 1'b0;
        tick();

        // Starvation: stage3/stage5 re-request continuously, stage12 held high.
        stage12_read = 1'b1; stage12_read_address = 16'h0004;
        stage3_read  = 1'b1;
        stage5_save  = 1'b1;
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            n++;
            if (grant == 2'd1) seen = 1'b1;
            else begin
                stage3_read = !stage3_read_ready;
                stage5_save = !stage5_save_ready;
            end
        end
        check("starve_seen", 32'(seen), 32'd1);
        check("starve_cycles", 32'(n), 32'd9);
        check("starve_cnt_clr", 32'(starve_cnt_dbg), 32'd0);
        stage3_read = 1'b0; stage5_save = 1'b0;
        wait_ready(1, 10, n);
        check("starve_rdy", 32'(n), 32'd2);
        check("starve_data", 32'(stage12_read_data_out), 32'h11);
        stage12_read = 1'b0;
        tick();

        // Request held high after ready is served only once.
        stage3_read = 1'b1; stage3_read_address = 16'h0020;
        pulses = 0;
        gcycles = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (stage3_read_ready) pulses++;
            if (grant == 2'd2) gcycles++;
        end
        check("hold_pulses", 32'(pulses), 32'd1);
        check("hold_grant_cycles", 32'(gcycles), 32'd2);
        check("hold_data", 32'(stage3_read_data_out), 32'h5A);
        stage3_read = 1'b0;
        tick();

        // Reset during WR: the write must not happen.
        stage5_save = 1'b1; stage5_save_address = 16'h0030; stage5_save_data_in = 8'hC3;
        tick();
        check("rwr_in_wr", 32'(state_dbg), 32'd3);
        rst = 1'b0;
        #1;
        check("rwr_we_drop", 32'(ram_write_enable), 32'd0);
        check("rwr_grant", 32'(grant), 32'd0);
        stage5_save = 1'b0;
        tick();
        check("rwr_mem", 32'(mem[16'h0030]), 32'h77);
        check("rwr_rdy", 32'(stage5_save_ready), 32'd0);
        check("rwr_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        tick();

        // Reset during RD_WAIT: no ready, data_out back to 0.
        stage3_read = 1'b1; stage3_read_address = 16'h0004;
        tick();
        check("rrd_in_wait", 32'(state_dbg), 32'd1);
        rst = 1'b0;
        #1;
        check("rrd_busy", 32'(busy), 32'd0);
        check("rrd_dout3", 32'(stage3_read_data_out), 32'd0);
        check("rrd_addr", 32'(ram_address), 32'd0);
        stage3_read = 1'b0;
        tick();
        check("rrd_rdy", 32'(stage3_read_ready), 32'd0);
        rst = 1'b1;
        tick();

        // Service resumes normally after reset.
        stage3_read = 1'b1; stage3_read_address = 16'h0004;
        wait_ready(2, 10, n);
        check("post_rst_latency", 32'(n), 32'd3);
        check("post_rst_data", 32'(stage3_read_data_out), 32'h11);
        stage3_read = 1'b0;
        stage5_save = 1'b1; stage5_save_address = 16'h0030; stage5_save_data_in = 8'hC3;
        wait_ready(3, 10, n);
        check("post_rst_wr_latency", 32'(n), 32'd2);
        check("post_rst_mem", 32'(mem[16'h0030]), 32'hC3);
        stage5_save = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
